// File: rtl/chrono_control.sv
// chrono_control: chronometer front end that debounces the buttons, runs the mode FSM and gates count ticks
// Ports:
//   qzt_clk        system clock, all logic on its rising edge
//   reset          synchronous active-low reset
//   start_stop_btn raw start/stop pushbutton, active-high, asynchronous
//   lap_reset_btn  raw lap/reset pushbutton, active-high, asynchronous
//   tick_in        divided time-base, synchronous to qzt_clk
//   tick_out       one-cycle count tick per tick_in rising edge while counting
//   clear          synchronous clear to the seconds/minutes counters
//   lap_capture    one-cycle load strobe for the lap register
//   display_sel    display mux address, 0 = live counters, 1 = lap register
//   state          IDLE=00, RUNNING=01, LAP=10, STOPPED=11
module chrono_control #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       start_stop_btn,
    input  logic       lap_reset_btn,
    input  logic       tick_in,
    output logic       tick_out,
    output logic       clear,
    output logic       lap_capture,
    output logic       display_sel,
    output logic [1:0] state
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, LAP = 2'b10, STOPPED = 2'b11} state_t;
    localparam logic [29:0] CNT_MAX = 30'(DEBOUNCE_CYCLES - 1);
    // bit 0 = start_stop, bit 1 = lap_reset
    logic [1:0]       sync1_q, sync2_q, deb_q, deb_d, deb_old_q, press_q, press_d;
    logic [1:0][29:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             tick_in_old_q, tick_out_q, tick_out_d, clear_q, clear_d;
    logic             lap_capture_q, lap_capture_d, display_sel_q, display_sel_d;
    logic             ss, lr, counting;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) deb_d[i] = ~deb_q[i];
                else cnt_d[i] = cnt_q[i] + 30'd1;
            end
        end
        // delayed edge detect on the debounced level: rise gives a press, fall gives nothing
        press_d = deb_q & ~deb_old_q;
    end
    always_comb begin
        ss       = press_q[0];
        lr       = press_q[1] & ~press_q[0];
        counting = (state_q == RUNNING) || (state_q == LAP);
        state_d  = state_q;
        unique case (state_q)
            IDLE:    state_d = ss ? RUNNING : IDLE;
            RUNNING: state_d = ss ? STOPPED : (lr ? LAP : RUNNING);
            LAP:     state_d = ss ? STOPPED : (lr ? RUNNING : LAP);
            STOPPED: state_d = ss ? RUNNING : (lr ? IDLE : STOPPED);
        endcase
        // clear only from non-counting states, so it can never coincide with tick_out
        clear_d       = lr && ((state_q == IDLE) || (state_q == STOPPED));
        lap_capture_d = lr && (state_q == RUNNING);
        display_sel_d = (state_d == LAP);
        tick_out_d    = tick_in & ~tick_in_old_q & counting;
    end
    always_ff @(posedge qzt_clk) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            deb_old_q     <= '0;
            press_q       <= '0;
            cnt_q         <= '0;
            state_q       <= IDLE;
            tick_in_old_q <= 1'b0;
            tick_out_q    <= 1'b0;
            clear_q       <= 1'b1;
            lap_capture_q <= 1'b0;
            display_sel_q <= 1'b0;
        end else begin
            sync1_q       <= {lap_reset_btn, start_stop_btn};
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            deb_old_q     <= deb_q;
            press_q       <= press_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            tick_in_old_q <= tick_in;
            tick_out_q    <= tick_out_d;
            clear_q       <= clear_d;
            lap_capture_q <= lap_capture_d;
            display_sel_q <= display_sel_d;
        end
    end
    assign tick_out    = tick_out_q;
    assign clear       = clear_q;
    assign lap_capture = lap_capture_q;
    assign display_sel = display_sel_q;
    assign state       = state_q;
endmodule

// File: tb/tb_chrono_control.sv
// tb_chrono_control: directed self-checking bench for chrono_control with DEBOUNCE_CYCLES=4
module tb_chrono_control;
  logic qzt_clk, reset, start_stop_btn, lap_reset_btn, tick_in;
  logic tick_out, clear, lap_capture, display_sel;
  logic [1:0] state;
  int checks = 0, failures = 0;
  int n_ticks = 0, n_clr = 0, n_lap = 0, n_both = 0;
  chrono_control #(.DEBOUNCE_CYCLES(4)) dut (
    .qzt_clk(qzt_clk), .reset(reset), .start_stop_btn(start_stop_btn),
    .lap_reset_btn(lap_reset_btn), .tick_in(tick_in), .tick_out(tick_out),
    .clear(clear), .lap_capture(lap_capture), .display_sel(display_sel), .state(state)
  );
  initial begin
    qzt_clk = 1'b0;
    forever #5 qzt_clk = ~qzt_clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge qzt_clk);
      #1;
      n_ticks += int'(tick_out);
      n_clr   += int'(clear);
      n_lap   += int'(lap_capture);
      n_both  += int'(tick_out & clear);
    end
  endtask
  task automatic press(input logic ss, input logic lr);
    start_stop_btn = ss;
    lap_reset_btn  = lr;
    cyc(8);
    start_stop_btn = 1'b0;
    lap_reset_btn  = 1'b0;
    cyc(8);
  endtask
  initial begin
    reset = 1'b0; start_stop_btn = 1'b0; lap_reset_btn = 1'b0; tick_in = 1'b0;
    cyc(3);
    chk("rst_state", state, 2'b00);
    chk("rst_clear", clear, 1'b1);
    chk("rst_tick", tick_out, 1'b0);
    chk("rst_lap", lap_capture, 1'b0);
    chk("rst_dsel", display_sel, 1'b0);
    reset = 1'b1;
    #1;
    chk("clear_after_deassert", clear, 1'b1);
    cyc(1);
    chk("clear_one_cycle", clear, 1'b0);
    start_stop_btn = 1'b1;
    cyc(7);
    chk("ss_latency_not_yet", state, 2'b00);
    cyc(1);
    chk("ss_to_running", state, 2'b01);
    cyc(2);
    start_stop_btn = 1'b0;
    cyc(8);
    lap_reset_btn = 1'b1;
    cyc(3);
    lap_reset_btn = 1'b0;
    cyc(10);
    chk("glitch_ignored", state, 2'b01);
    chk("glitch_no_dsel", display_sel, 1'b0);
    n_ticks = 0;
    for (int p = 0; p < 2; p++) begin
      tick_in = 1'b1;
      cyc(1);
      chk("run_tick_hi", tick_out, 1'b1);
      cyc(1);
      chk("run_tick_lo", tick_out, 1'b0);
      cyc(2);
      tick_in = 1'b0;
      cyc(4);
    end
    chk("run_tick_count", n_ticks, 2);
    n_lap = 0;
    press(1'b0, 1'b1);
    chk("lap_state", state, 2'b10);
    chk("lap_dsel", display_sel, 1'b1);
    chk("lap_capture_once", n_lap, 1);
    tick_in = 1'b1;
    cyc(1);
    chk("lap_tick", tick_out, 1'b1);
    cyc(3);
    tick_in = 1'b0;
    cyc(4);
    press(1'b0, 1'b1);
    chk("lap_back_run", state, 2'b01);
    chk("lap_back_dsel", display_sel, 1'b0);
    press(1'b1, 1'b0);
    chk("stopped_state", state, 2'b11);
    n_ticks = 0;
    tick_in = 1'b1;
    cyc(4);
    tick_in = 1'b0;
    cyc(4);
    chk("stopped_no_tick", n_ticks, 0);
    n_clr = 0;
    press(1'b0, 1'b1);
    chk("stop_lr_idle", state, 2'b00);
    chk("stop_lr_clear", n_clr, 1);
    press(1'b0, 1'b1);
    chk("idle_lr_idle", state, 2'b00);
    chk("idle_lr_clear2", n_clr, 2);
    n_clr = 0; n_lap = 0;
    press(1'b1, 1'b1);
    chk("both_state", state, 2'b01);
    chk("both_no_clear", n_clr, 0);
    chk("both_no_lap", n_lap, 0);
    start_stop_btn = 1'b1;
    cyc(7);
    tick_in = 1'b1;
    cyc(1);
    chk("stop_edge_state", state, 2'b11);
    chk("stop_edge_tick", tick_out, 1'b1);
    cyc(1);
    chk("stop_edge_tick_end", tick_out, 1'b0);
    start_stop_btn = 1'b0;
    cyc(8);
    n_ticks = 0;
    press(1'b1, 1'b0);
    chk("restart_state", state, 2'b01);
    chk("restart_no_tick", n_ticks, 0);
    tick_in = 1'b0;
    cyc(2);
    tick_in = 1'b1;
    cyc(1);
    chk("restart_next_edge", tick_out, 1'b1);
    tick_in = 1'b0;
    start_stop_btn = 1'b1;
    cyc(3);
    reset = 1'b0;
    start_stop_btn = 1'b0;
    cyc(3);
    chk("midrst_clear", clear, 1'b1);
    reset = 1'b1;
    cyc(12);
    chk("midrst_no_press", state, 2'b00);
    chk("never_clear_and_tick", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chrono_control.md
Name: chrono_control

Overview:
- Front-end controller for the start/stop/lap/reset chronometer.
- Debounces the two pushbuttons and runs the chronometer mode FSM.
- Gates the divided time-base into single-cycle count ticks that drive the clk_in input of the seconds/minutes synchro counters.
- Drives the counters' clear, the lap-register capture and the 2-input display mux address.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive qzt_clk cycles a button level must stay stable before it is accepted (10 ms at 50 MHz); legal range 2..2^30-1.

Ports:
- qzt_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start_stop_btn  input  1  raw pushbutton, active-high, asynchronous to qzt_clk.
- lap_reset_btn  input  1  raw pushbutton, active-high, asynchronous to qzt_clk.
- tick_in  input  1  time-base from the frequency divider, synchronous to qzt_clk.
- tick_out  output  1  one-cycle pulse per accepted tick_in rising edge while counting.
- clear  output  1  synchronous clear to the counters.
- lap_capture  output  1  one-cycle load strobe for the lap register.
- display_sel  output  1  display mux address: 0 = live counters, 1 = lap register.
- state  output  2  FSM state: IDLE=00, RUNNING=01, LAP=10, STOPPED=11.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, tick_out=0, lap_capture=0, display_sel=0, clear=1.
  - All synchronisers, debounce counters and debounced levels are cleared to 0.
  - clear stays 1 for exactly one cycle after reset deasserts, then 0.
- Button path, per button:
  - 2-FF synchroniser, then a 30-bit stability counter.
  - The counter is cleared whenever the synchronised level equals the debounced level; otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - A flip to 1 produces a one-cycle press pulse; release produces no pulse.
  - Latency: raw rise held stable → press pulse is high in the cycle DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the raw high.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Simultaneous press pulses in the same cycle: start_stop wins; the lap_reset pulse is discarded.
- FSM transitions (ss = start_stop press, lr = lap_reset press; other cases hold state):
  - IDLE: ss → RUNNING; lr → IDLE, with a one-cycle clear pulse.
  - RUNNING: ss → STOPPED; lr → LAP, with a lap_capture pulse in the cycle state becomes LAP.
  - LAP: lr → RUNNING (display back to live); ss → STOPPED.
  - STOPPED: ss → RUNNING; lr → IDLE, with a one-cycle clear pulse in the cycle state becomes IDLE.
- display_sel = 1 only in state LAP; it is a registered output and changes in the same cycle as state.
- Tick gating:
  - tick_in_old is registered every cycle, including when not running.
  - tick_out <= tick_in & ~tick_in_old & (state==RUNNING | state==LAP), using the registered state.
  - Latency: one cycle after the first cycle tick_in is sampled high.
  - A tick_in edge coinciding with a stop transition is still counted if the pre-transition state was counting.
  - Restarting while tick_in is already high produces no tick until its next rising edge.
- clear and tick_out are never high in the same cycle; clear only occurs from IDLE/STOPPED, where tick_out is forced 0.
- Reset mid-press or mid-debounce: the press is lost; the button must be released and pressed again.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles, then released → state=00, clear=1 for exactly 1 cycle, all other outputs 0.
- start_stop_btn high for 10 cycles → single press pulse 6 cycles after the first sampling edge; state 00→01; a 3-cycle glitch on lap_reset_btn causes no change.
- In RUNNING, tick_in square wave period 8 → tick_out 1-cycle pulses every 8 cycles. Press lap → state=10, display_sel=1, one lap_capture pulse, ticks continue. Press lap again → state=01, display_sel=0.
- RUNNING, press start_stop → state=11, tick_out stays 0. Press lap → state=00 with one clear pulse. Press lap again in IDLE → a second clear pulse, state stays 00.
- Both buttons rise in the same cycle from IDLE → state=01 only, no clear, no lap_capture.
- Stop with tick_in high, restart while still high → no tick_out until the next tick_in rising edge; reset asserted during a debounce count → no press pulse after release.
